// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle MIPS main control.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;

endpackage

// File: rtl/mcpu_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute and
// drives the datapath strobes and the ALU-op bus.
module mcpu_main_control
  import mcpu_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_IRWrite,
  output logic       o_MemtoReg,
  output logic       o_RegDst,
  output logic       o_RegWrite,
  output logic       o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_PCSource,
  output logic [2:0] o_ALUop,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] r_op;
  logic       ready;

  assign ready = MEM_WAIT_EN ? i_mem_ready : 1'b1;

  // State register; opcode captured while decoding so later IR changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_FETCH;
      r_op  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) r_op <= i_opcode;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt     = S_FETCH;
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_IorD        = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_IRWrite     = 1'b0;
    o_MemtoReg    = 1'b0;
    o_RegDst      = 1'b0;
    o_RegWrite    = 1'b0;
    o_ALUSrcA     = 1'b0;
    o_ALUSrcB     = 2'b00;
    o_PCSource    = 2'b00;
    o_ALUop       = ALUOP_ADD;
    o_illegal     = 1'b0;
    o_state       = state;

    case (state)
      S_FETCH: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = 2'b01;
        o_IRWrite = ready;
        o_PCWrite = ready;
        state_nxt = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        o_ALUSrcB = 2'b11;
        case (i_opcode)
          OP_LW, OP_SW:               state_nxt = S_MEMADR;
          OP_RTYPE:                   state_nxt = S_EXEC;
          OP_BEQ:                     state_nxt = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_SLTI:  state_nxt = S_IEXEC;
          OP_J:                       state_nxt = S_JUMP;
          default: begin
            o_illegal = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = 2'b10;
        state_nxt = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_MemRead = 1'b1;
        o_IorD    = 1'b1;
        state_nxt = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        o_RegWrite = 1'b1;
        o_MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        o_MemWrite = 1'b1;
        o_IorD     = 1'b1;
        state_nxt  = ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        o_ALUSrcA = 1'b1;
        o_ALUop   = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        o_RegWrite = 1'b1;
        o_RegDst   = 1'b1;
      end
      S_BRANCH: begin
        o_ALUSrcA     = 1'b1;
        o_ALUop       = ALUOP_SUB;
        o_PCWriteCond = 1'b1;
        o_PCSource    = 2'b01;
      end
      S_IEXEC: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = 2'b10;
        case (r_op)
          OP_ANDI: o_ALUop = ALUOP_AND;
          OP_SLTI: o_ALUop = ALUOP_SLT;
          default: o_ALUop = ALUOP_ADD;
        endcase
        state_nxt = S_IWB;
      end
      S_IWB: begin
        o_RegWrite = 1'b1;
      end
      S_JUMP: begin
        o_PCWrite  = 1'b1;
        o_PCSource = 2'b10;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset takes effect at the next edge, so outputs are forced quiet
    // combinationally to keep write strobes off in the reset cycle itself.
    if (i_rst) begin
      o_PCWrite     = 1'b0;
      o_PCWriteCond = 1'b0;
      o_IorD        = 1'b0;
      o_MemRead     = 1'b0;
      o_MemWrite    = 1'b0;
      o_IRWrite     = 1'b0;
      o_MemtoReg    = 1'b0;
      o_RegDst      = 1'b0;
      o_RegWrite    = 1'b0;
      o_ALUSrcA     = 1'b0;
      o_ALUSrcB     = 2'b00;
      o_PCSource    = 2'b00;
      o_ALUop       = ALUOP_ADD;
      o_illegal     = 1'b0;
      o_state       = S_FETCH;
    end
  end

endmodule

// File: tb/tb_mcpu_main_control.sv
// Scoreboard bench for mcpu_main_control: an instruction-level reference
// model queues the expected control vector for every cycle; a monitor
// compares on the falling edge.
module tb_mcpu_main_control;

  // Phase numbers as they appear on o_state.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_IEXEC = 9,
                 P_IWB = 10, P_JUMP = 11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100, SLTI = 6'b001010;

  logic       clk = 1'b0;
  logic       i_rst, i_mem_ready;
  logic [5:0] i_opcode;
  logic       o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite, o_IRWrite;
  logic       o_MemtoReg, o_RegDst, o_RegWrite, o_ALUSrcA, o_illegal;
  logic [1:0] o_ALUSrcB, o_PCSource;
  logic [2:0] o_ALUop;
  logic [3:0] o_state;

  int vectors = 0;
  int miscompares = 0;
  logic [21:0] expq[$];
  logic [21:0] act;

  always #5 clk = ~clk;

  mcpu_main_control #(.MEM_WAIT_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
    .o_PCWrite(o_PCWrite), .o_PCWriteCond(o_PCWriteCond), .o_IorD(o_IorD),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_IRWrite(o_IRWrite),
    .o_MemtoReg(o_MemtoReg), .o_RegDst(o_RegDst), .o_RegWrite(o_RegWrite),
    .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB), .o_PCSource(o_PCSource),
    .o_ALUop(o_ALUop), .o_illegal(o_illegal), .o_state(o_state)
  );

  assign act = {o_illegal, o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite,
                o_IRWrite, o_MemtoReg, o_RegDst, o_RegWrite, o_ALUSrcA, o_ALUSrcB,
                o_PCSource, o_ALUop, o_state};

  function automatic bit legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI, ANDI, SLTI};
  endfunction

  // Expected control vector for one phase of an instruction.
  function automatic logic [21:0] ctl(input int p, input logic [5:0] op, input logic rdy);
    logic ill, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] alu;
    logic [3:0] st;
    {ill, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; pcsrc = 2'b00; alu = 3'b000;
    st = 4'(p);
    case (p)
      P_FETCH:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE: begin srcb = 2'b11; ill = !legal(op); end
      P_MEMADR: begin srca = 1; srcb = 2'b10; end
      P_MEMRD:  begin mr = 1; iord = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin mw = 1; iord = 1; end
      P_EXEC:   begin srca = 1; alu = 3'b010; end
      P_ALUWB:  begin rw = 1; rdst = 1; end
      P_BRANCH: begin srca = 1; alu = 3'b001; pcwc = 1; pcsrc = 2'b01; end
      P_IEXEC:  begin
        srca = 1; srcb = 2'b10;
        alu = (op == ANDI) ? 3'b011 : (op == SLTI) ? 3'b100 : 3'b000;
      end
      P_IWB:    rw = 1;
      P_JUMP:   begin pcw = 1; pcsrc = 2'b10; end
      default:  ;
    endcase
    return {ill, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, pcsrc, alu, st};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic apply(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [21:0] e);
    @(posedge clk);
    #1;
    i_rst = rst; i_opcode = op; i_mem_ready = rdy;
    expq.push_back(e);
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom_range(0, 63));
  endfunction

  // Whole instruction: fetch, decode, then the phases the opcode calls for.
  task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait);
    int ph[$];
    ph = '{P_FETCH, P_DECODE};
    case (op)
      LW:               ph = {ph, P_MEMADR, P_MEMRD, P_MEMWB};
      SW:               ph = {ph, P_MEMADR, P_MEMWR};
      RT:               ph = {ph, P_EXEC, P_ALUWB};
      BEQ:              ph.push_back(P_BRANCH);
      ADDI, ANDI, SLTI: ph = {ph, P_IEXEC, P_IWB};
      JMP:              ph.push_back(P_JUMP);
      default:          ;
    endcase
    foreach (ph[k]) begin
      int p;
      p = ph[k];
      if (p == P_FETCH || p == P_MEMRD || p == P_MEMWR) begin
        int n;
        n = (p == P_FETCH) ? fetch_wait : mem_wait;
        for (int w = 0; w < n; w++) apply(1'b0, junk(), 1'b0, ctl(p, op, 1'b0));
        apply(1'b0, junk(), 1'b1, ctl(p, op, 1'b1));
      end else begin
        apply(1'b0, (p == P_DECODE) ? op : junk(), 1'($urandom_range(0, 1)), ctl(p, op, 1'b1));
      end
    end
  endtask

  // sw stalled in the write phase, then reset for 3 cycles.
  task automatic reset_mid_memwr();
    apply(1'b0, junk(), 1'b1, ctl(P_FETCH, SW, 1'b1));
    apply(1'b0, SW, 1'b0, ctl(P_DECODE, SW, 1'b1));
    apply(1'b0, junk(), 1'b0, ctl(P_MEMADR, SW, 1'b1));
    for (int w = 0; w < 2; w++) apply(1'b0, junk(), 1'b0, ctl(P_MEMWR, SW, 1'b0));
    for (int r = 0; r < 3; r++) apply(1'b1, junk(), 1'($urandom_range(0, 1)), '0);
  endtask

  // Monitor: one expected vector per cycle, checked mid-cycle.
  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL ctrl vec=%0d state=%0d got=%b exp=%b", vectors, o_state, act, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[8];
    logic [5:0] op;
    ops = '{LW, SW, RT, BEQ, JMP, ADDI, ANDI, SLTI};
    i_rst = 1'b1; i_opcode = '0; i_mem_ready = 1'b0;

    for (int r = 0; r < 3; r++) apply(1'b1, junk(), 1'($urandom_range(0, 1)), '0);

    run_instr(LW, 0, 0);
    run_instr(ADDI, 3, 0);
    run_instr(ADDI, 0, 0);
    run_instr(ANDI, 0, 0);
    run_instr(SLTI, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(JMP, 0, 0);
    run_instr(RT, 0, 0);
    run_instr(SW, 0, 2);
    run_instr(LW, 1, 3);
    run_instr(6'b111111, 0, 0);
    run_instr(LW, 0, 0);
    reset_mid_memwr();
    run_instr(JMP, 0, 0);

    for (int i = 0; i < 300; i++) begin
      int pick;
      pick = $urandom_range(0, 9);
      if (pick < 8) op = ops[pick];
      else begin
        op = junk();
        while (legal(op)) op = junk();
      end
      if ($urandom_range(0, 39) == 0) reset_mid_memwr();
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    @(negedge clk);
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending exp=0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
